ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs,
//  0xFF reset) to the keyboard over the shared open-collector PS2C/PS2D lines.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_clk_filter.sv | 55 +++++
 rtl/ps2_host_tx.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit types, command bytes and parity helper.
// Imported by the transmitter and the PS2C clock filter.
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAITREL,
    ST_DONE
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS2C conditioner: 2-FF sync, FILTER_LEN-sample debounce, fall strobe.
// Ports: clk, rst_n, ps2c_i (raw pin) -> level_o (filtered), fall_o (1-cycle).
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level;
  // the FILTER_LEN-th one flips it. Any agreeing sample restarts the run.
  always_comb begin
    level_d = level_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        fall_d  = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Idle bus level is high, so the pipeline resets to 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], ps2c_i};
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop, device ACK. Lines driven by output-enable only.
// Ports: clk, rst_n, tx_data, tx_start, ps2c_in, ps2d_in -> ps2c_oe,
// ps2d_oe, tx_busy, tx_done, ack_err.
// Build option: PS2_TX_TIMEOUT_EN adds a whole-frame watchdog.
module ps2_host_tx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int INHIBIT_US = 100,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       ack_err
);

  import ps2_pkg::*;

  localparam int INH_C =
    int'((64'(INHIBIT_US) * 64'(CLK_HZ)) / 64'd1000000);
  localparam int INH_N = (INH_C < 1) ? 1 : INH_C;
  localparam int IW    = $clog2(INH_N + 1);

  localparam int TO_C =
    int'((64'(TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1000000);
  localparam int TO_N  = (TO_C < 1) ? 1 : TO_C;
  localparam int WW    = $clog2(TO_N + 1);

  ps2_tx_state_e state_q, state_d;

  logic [IW-1:0] inh_q, inh_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shf_q, shf_d;
  logic          par_q, par_d;
  logic          doe_q, doe_d;
  logic          err_q, err_d;
  logic          arm_q, arm_d;
  logic [1:0]    dsync_q;

  logic c_level, c_fall;
  logic [2:0] bit_nx;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_cflt (
    .clk    (clk),
    .rst_n  (rst_n),
    .ps2c_i (ps2c_in),
    .level_o(c_level),
    .fall_o (c_fall)
  );

  assign bit_nx = bit_q + 3'd1;

`ifdef PS2_TX_TIMEOUT_EN
  logic [WW-1:0] wd_q, wd_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(TO_N), 32'(WW)};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      inh_q   <= '0;
      bit_q   <= '0;
      shf_q   <= '0;
      par_q   <= 1'b0;
      doe_q   <= 1'b0;
      err_q   <= 1'b0;
      arm_q   <= 1'b0;
      dsync_q <= 2'b11;
    end else begin
      state_q <= state_d;
      inh_q   <= inh_d;
      bit_q   <= bit_d;
      shf_q   <= shf_d;
      par_q   <= par_d;
      doe_q   <= doe_d;
      err_q   <= err_d;
      arm_q   <= arm_d;
      dsync_q <= {dsync_q[0], ps2d_in};
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    inh_d   = inh_q;
    bit_d   = bit_q;
    shf_d   = shf_q;
    par_d   = par_q;
    doe_d   = doe_q;
    err_d   = err_q;
    arm_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d = ST_INHIBIT;
          shf_d   = tx_data;
          par_d   = ps2_odd_parity(tx_data);
          inh_d   = '0;
          bit_d   = '0;
          err_d   = 1'b0;
          doe_d   = 1'b0;
        end
      end
      ST_INHIBIT: begin
        // Counter stops at its terminal value; the start bit goes
        // onto PS2D as the clock is released.
        if (inh_q == IW'(INH_N - 1)) begin
          doe_d   = 1'b1;
          state_d = ST_REQ;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      ST_REQ: begin
        // Our own inhibit edge reaches the filter late; only accept a
        // fall once the released clock has been seen high again.
        arm_d = arm_q | c_level;
        if (c_fall && arm_q) begin
          doe_d   = ~shf_q[0];
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (c_fall) begin
          bit_d = bit_nx;
          doe_d = ~shf_q[bit_nx];
          if (bit_q == 3'd6) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (c_fall) begin
          doe_d   = ~par_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (c_fall) begin
          doe_d   = 1'b0;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (c_fall) begin
          err_d   = dsync_q[1];
          state_d = ST_WAITREL;
        end
      end
      ST_WAITREL: begin
        if (c_level && dsync_q[1]) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        doe_d   = 1'b0;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wd_d = wd_q;
    if (state_q == ST_IDLE) begin
      wd_d = '0;
    end else if (wd_q != WW'(TO_N)) begin
      wd_d = wd_q + 1'b1;
    end
    if (state_q != ST_IDLE && state_q != ST_DONE &&
        wd_q == WW'(TO_N - 1)) begin
      state_d = ST_DONE;
      doe_d   = 1'b0;
      err_d   = 1'b1;
    end
`endif
  end

  always_comb begin
    ps2c_oe = (state_q == ST_INHIBIT);
    ps2d_oe = doe_q;
    tx_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
    tx_done = (state_q == ST_DONE);
    ack_err = (state_q == ST_DONE) && err_q;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device BFM on open-collector lines, scoreboard
// of expected frames, table of frame vectors plus reset/timeout sequences.
module tb_ps2_host_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe;
  logic       tx_busy, tx_done, ack_err;
  logic       dev_c_low, dev_d_low;

  int n_cmp = 0;
  int n_bad = 0;

  int   done_cnt = 0;
  logic done_err [0:31];

  typedef struct {
    logic [7:0] data;
    logic       do_ack;
    int         glitch;
    int         mid;
    logic       par;
    logic       err;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       err;
  } exp_t;

  vec_t tbl [6];
  exp_t sb [$];

  ps2_host_tx #(
    .CLK_HZ    (1_000_000),
    .INHIBIT_US(10),
    .FILTER_LEN(8),
    .TIMEOUT_US(2000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_start(tx_start),
    .ps2c_in (ps2c_in),
    .ps2d_in (ps2d_in),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .ack_err (ack_err)
  );

  assign ps2c_in = ~(ps2c_oe | dev_c_low);
  assign ps2d_in = ~(ps2d_oe | dev_d_low);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done && done_cnt < 32) begin
      done_err[done_cnt] <= ack_err;
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    cyc(1);
    tx_start = 1'b0;
  endtask

  // Device side: watch inhibit, then clock 11 falling edges, sampling
  // PS2D at each rising edge. Optional glitch, mid-frame start pulse,
  // missing ACK, or early return while clock is held low.
  task automatic dev_frame(input logic do_ack, input int glitch,
                           input int mid, input int stop_edge,
                           output logic [10:0] got);
    int n;
    got = '0;
    n = 0;
    while (!ps2c_oe && n < 100) begin
      cyc(1);
      n++;
    end
    chk("inhibit_seen", 32'(ps2c_oe), 32'd1);
    n = 0;
    while (ps2c_oe && n < 100) begin
      cyc(1);
      n++;
    end
    chk("inhibit_len", 32'(n), 32'd10);
    chk("start_bit", 32'(ps2d_in), 32'd0);
    got[0] = ps2d_in;
    cyc(30);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && do_ack) begin
        cyc(20);
        dev_d_low = 1'b1;
        cyc(20);
      end else if (k == glitch) begin
        cyc(15);
        dev_c_low = 1'b1;
        cyc(4);
        dev_c_low = 1'b0;
        cyc(21);
      end else begin
        cyc(40);
      end
      dev_c_low = 1'b1;
      if (k == mid) begin
        cyc(10);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        cyc(1);
        tx_start = 1'b0;
        cyc(9);
      end else begin
        cyc(20);
      end
      if (k == stop_edge) return;
      cyc(20);
      dev_c_low = 1'b0;
      if (k <= 10) got[4'(k)] = ps2d_in;
    end
    cyc(20);
    dev_d_low = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int lim, output int w);
    w = 0;
    while (done_cnt <= idx && w < lim) begin
      cyc(1);
      w++;
    end
  endtask

  initial begin
    logic [10:0] got;
    exp_t e;
    int   idx;
    int   w;

    tbl[0] = '{8'hED, 1'b1, 0, 0, 1'b1, 1'b0};
    tbl[1] = '{8'h01, 1'b1, 0, 0, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 1'b1, 0, 0, 1'b1, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 5, 0, 1'b1, 1'b0};
    tbl[4] = '{8'hED, 1'b0, 0, 0, 1'b1, 1'b1};
    tbl[5] = '{8'hED, 1'b1, 0, 4, 1'b1, 1'b0};

    rst_n     = 1'b0;
    tx_data   = 8'h00;
    tx_start  = 1'b0;
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;
    cyc(3);
    chk("rst_c_oe", 32'(ps2c_oe), 32'd0);
    chk("rst_d_oe", 32'(ps2d_oe), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_err", 32'(ack_err), 32'd0);
    rst_n = 1'b1;
    cyc(20);

    for (int i = 0; i < 6; i++) begin
      idx = done_cnt;
      sb.push_back('{tbl[i].data, tbl[i].par, tbl[i].err});
      send(tbl[i].data);
      chk("busy_after_accept", 32'(tx_busy), 32'd1);
      dev_frame(tbl[i].do_ack, tbl[i].glitch, tbl[i].mid, 0, got);
      wait_done(idx, 300, w);
      e = sb.pop_front();
      chk("data_bits", 32'(got[8:1]), 32'(e.data));
      chk("parity_bit", 32'(got[9]), 32'(e.par));
      chk("stop_bit", 32'(got[10]), 32'd1);
      chk("done_seen", 32'(done_cnt > idx), 32'd1);
      if (done_cnt > idx) chk("ack_err", 32'(done_err[idx]), 32'(e.err));
      cyc(30);
      chk("idle_busy", 32'(tx_busy), 32'd0);
      chk("one_done", 32'(done_cnt), 32'(idx + 1));
    end

    // Reset while bit 4 of 0xED (a 0, so PS2D pulled) is on the line.
    idx = done_cnt;
    send(8'hED);
    dev_frame(1'b1, 0, 0, 5, got);
    chk("pre_rst_d_oe", 32'(ps2d_oe), 32'd1);
    chk("pre_rst_busy", 32'(tx_busy), 32'd1);
    rst_n = 1'b0;
    cyc(1);
    chk("midrst_c_oe", 32'(ps2c_oe), 32'd0);
    chk("midrst_d_oe", 32'(ps2d_oe), 32'd0);
    chk("midrst_busy", 32'(tx_busy), 32'd0);
    rst_n     = 1'b1;
    dev_c_low = 1'b0;
    cyc(40);
    chk("midrst_no_done", 32'(done_cnt), 32'(idx));
    chk("midrst_idle", 32'(tx_busy), 32'd0);

`ifdef PS2_TX_TIMEOUT_EN
    idx = done_cnt;
    sb.push_back('{8'hED, 1'b1, 1'b1});
    send(8'hED);
    wait_done(idx, 2100, w);
    e = sb.pop_front();
    chk("to_done_seen", 32'(done_cnt > idx), 32'd1);
    chk("to_latency", 32'(w >= 1990 && w <= 2005), 32'd1);
    if (done_cnt > idx) chk("to_ack_err", 32'(done_err[idx]), 32'(e.err));
    chk("to_d_oe", 32'(ps2d_oe), 32'd0);
    chk("to_c_oe", 32'(ps2c_oe), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
